// File: rtl/accel_mul_scheduler.sv
// Two-requester round-robin front end sharing one sequential shift-add multiplier.
// Optional macro ACCEL_MUL_EARLY_EXIT_EN ends MUL once no multiplier bits remain.
module accel_mul_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_overflow,
    output logic             busy,
    output logic             grant_id
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_q, grant_d;
    logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d, result_q, result_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               r0v_q, r0v_d, r1v_q, r1v_d;
    logic               rdy0, rdy1, accept, mul_last;
    logic [WIDTH-1:0]   sel_a, sel_b;

    // On a tie the requester that did not win last time is readied.
    assign rdy0   = (state_q == S_IDLE) && req0_valid && (!req1_valid || last_grant_q);
    assign rdy1   = (state_q == S_IDLE) && req1_valid && (!req0_valid || !last_grant_q);
    assign accept = rdy0 || rdy1;
    assign sel_a  = rdy1 ? req1_a : req0_a;
    assign sel_b  = rdy1 ? req1_b : req0_b;

`ifdef ACCEL_MUL_EARLY_EXIT_EN
    assign mul_last = (cnt_q == CW'(WIDTH-1)) || (b_q[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt_q == CW'(WIDTH-1));
`endif

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            r0v_q        <= 1'b0;
            r1v_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            r0v_q        <= r0v_d;
            r1v_q        <= r1v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef ACCEL_MUL_EARLY_EXIT_EN
                    state_d = (sel_b == '0) ? S_DONE : S_MUL;
`else
                    state_d = S_MUL;
`endif
                end
            end
            S_MUL:   if (mul_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        r0v_d        = 1'b0;
        r1v_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d          = {{WIDTH{1'b0}}, sel_a};
                    b_d          = sel_b;
                    grant_d      = rdy1;
                    last_grant_d = rdy1;
                    acc_d        = '0;
                    cnt_d        = '0;
                end
            end
            S_MUL: begin
                // a_q carries a << i, so each step adds the shifted multiplicand.
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
            end
            S_DONE: begin
                result_d = acc_q[WIDTH-1:0];
                ovf_d    = |acc_q[2*WIDTH-1:WIDTH];
                r0v_d    = !grant_q;
                r1v_d    = grant_q;
            end
            default: ;
        endcase
    end

    assign req0_ready    = rdy0;
    assign req1_ready    = rdy1;
    assign resp0_valid   = r0v_q;
    assign resp1_valid   = r1v_q;
    assign resp_result   = result_q;
    assign resp_overflow = ovf_q;
    assign busy          = (state_q == S_MUL) || (state_q == S_DONE);
    assign grant_id      = grant_q;
endmodule

// File: tb/tb_accel_mul_scheduler.sv
// Directed bench for accel_mul_scheduler: single ops, overflow, arbitration, reset abort.
module tb_accel_mul_scheduler;
    localparam int W = 16;
`ifdef ACCEL_MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic         clk, wb_rst_i;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, resp_result;
    logic         resp0_valid, resp1_valid, resp_overflow, busy, grant_id;

    int vectors = 0;
    int miscompares = 0;

    accel_mul_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .wb_rst_i(wb_rst_i),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_result(resp_result), .resp_overflow(resp_overflow),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated request; latency counted in negedges after the acceptance edge.
    task automatic run_op(input string tag, input bit n, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic eo, input int el);
        int lat;
        bit got;
        @(negedge clk);
        if (!n) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else    begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        #1;
        chk({tag, "_ready"}, n ? req1_ready : req0_ready, 1);
        chk({tag, "_other_ready"}, n ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk); lat++;
            if (resp0_valid || resp1_valid) got = 1'b1;
        end
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_resp_own"}, n ? resp1_valid : resp0_valid, 1);
        chk({tag, "_resp_other"}, n ? resp0_valid : resp1_valid, 0);
        chk({tag, "_result"}, resp_result, er);
        chk({tag, "_ovf"}, resp_overflow, eo);
        chk({tag, "_grant"}, grant_id, n);
        @(negedge clk);
        chk({tag, "_pulse_end"}, resp0_valid | resp1_valid, 0);
    endtask

    initial begin
        int exp_order [4];
        logic [W-1:0] exp_res [4];
        int w, pulses;
        exp_order = '{0, 1, 0, 1};
        exp_res   = '{16'd15, 16'd110, 16'd63, 16'h4E20};

        wb_rst_i = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_resp", {resp0_valid, resp1_valid, resp_overflow, grant_id}, 0);
        chk("rst_result", resp_result, 0);
        @(negedge clk); wb_rst_i = 1'b0;

        run_op("r0_3x5", 1'b0, 16'd3, 16'd5, 16'd15, 1'b0, W + 2);
        run_op("r1_ovf", 1'b1, 16'h0100, 16'h0100, 16'h0000, 1'b1, W + 2);
        run_op("r1_ffff", 1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, EE ? 3 : W + 2);
        run_op("r0_b0", 1'b0, 16'd5, 16'd0, 16'd0, 1'b0, EE ? 2 : W + 2);
        run_op("r0_a0", 1'b0, 16'd0, 16'h8000, 16'd0, 1'b0, W + 2);
        run_op("r0_max", 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, W + 2);

        // Fresh reset so both-valid arbitration starts from last_grant=1.
        @(negedge clk); wb_rst_i = 1'b1; #1; wb_rst_i = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'd3;  req0_b = 16'd5;
        req1_valid = 1'b1; req1_a = 16'd10; req1_b = 16'd11;
        #1;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!(req0_ready || req1_ready) && w < 100) begin @(negedge clk); #1; w++; end
            chk("arb_both_ready", req0_ready & req1_ready, 0);
            chk("arb_order", req1_ready, exp_order[k]);
            @(posedge clk); #1;
            case (k)
                0: begin req0_a = 16'd7;   req0_b = 16'd9;   end
                1: begin req1_a = 16'd100; req1_b = 16'd200; end
                2: req0_valid = 1'b0;
                default: req1_valid = 1'b0;
            endcase
            w = 0;
            while (!(resp0_valid || resp1_valid) && w < 100) begin @(negedge clk); #1; w++; end
            chk("arb_result", resp_result, exp_res[k]);
            chk("arb_grant", grant_id, exp_order[k]);
            chk("arb_resp1", resp1_valid, exp_order[k]);
        end

        // Abort a req1 op mid-MUL with an async reset.
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 16'd9; req1_b = 16'd9;
        @(posedge clk); #1; req1_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant_id, 0);
        chk("abort_result", resp_result, 0);
        chk("abort_flags", {resp0_valid, resp1_valid, resp_overflow}, 0);
        #3 wb_rst_i = 1'b0;
        pulses = 0;
        repeat (W + 8) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) pulses++;
        end
        chk("abort_no_resp", pulses, 0);
        run_op("post_rst", 1'b0, 16'd6, 16'd7, 16'd42, 1'b0, W + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
